shadow_reg_stack: RTL

Multi-level shadow register stack for nested interrupt handling. On interrupt entry it saves a parametrised set of GPRs plus mepc/mcause into a stack frame, one register per cycle. On mret it restores the top frame into the register file the same way. A hazard port tells issue which registers are not yet saved or restored. It sits beside issue/read-operands, between the CSR regfile (save/restore requests, frame readback) and the GPR file (read and write ports).

---
 rtl/shadow_reg_stack_if.sv | 57 +++++
 rtl/shadow_reg_stack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_reg_stack_if.sv
// Bundle of the shadow register stack's request, GPR-port, hazard and CSR readback signals.
// Signal suffixes are from the stack's point of view (_i into the stack, _o out of it).
//   slave  : the stack itself.
//   master : the environment, which is the CSR regfile, GPR file and issue logic.
// Save/restore handshakes : save_valid_i/save_ready_o, restore_valid_i/restore_ready_o,
//                           restore_err_o, save_done_o, restore_done_o.
// GPR file ports          : rf_raddr_o/rf_rdata_i (combinational read), rf_we_o/rf_waddr_o/rf_wdata_o.
// Issue hazard            : hazard_addr_i -> hazard_o.
// CSR side                : save_mepc_i/save_mcause_i, restored_mepc_o/restored_mcause_o,
//                           csr_raddr_i/csr_rdata_o, level_o, depth_o.
interface shadow_reg_stack_if #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NrShadowRegs = 16,
  parameter int unsigned Depth        = 4
);
  localparam int unsigned DepthW = $clog2(Depth + 1);
  localparam int unsigned CsrAW  = $clog2(NrShadowRegs + 2);

  logic              save_valid_i;
  logic              save_ready_o;
  logic [XLEN-1:0]   save_mepc_i;
  logic [XLEN-1:0]   save_mcause_i;
  logic              restore_valid_i;
  logic              restore_ready_o;
  logic              restore_err_o;
  logic              save_done_o;
  logic              restore_done_o;
  logic [4:0]        rf_raddr_o;
  logic [XLEN-1:0]   rf_rdata_i;
  logic              rf_we_o;
  logic [4:0]        rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic [XLEN-1:0]   restored_mepc_o;
  logic [XLEN-1:0]   restored_mcause_o;
  logic [4:0]        hazard_addr_i;
  logic              hazard_o;
  logic [4:0]        level_o;
  logic [DepthW-1:0] depth_o;
  logic [CsrAW-1:0]  csr_raddr_i;
  logic [XLEN-1:0]   csr_rdata_o;

  modport slave (
    input  save_valid_i, save_mepc_i, save_mcause_i, restore_valid_i, rf_rdata_i,
           hazard_addr_i, csr_raddr_i,
    output save_ready_o, restore_ready_o, restore_err_o, save_done_o, restore_done_o,
           rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, restored_mepc_o, restored_mcause_o,
           hazard_o, level_o, depth_o, csr_rdata_o
  );

  modport master (
    output save_valid_i, save_mepc_i, save_mcause_i, restore_valid_i, rf_rdata_i,
           hazard_addr_i, csr_raddr_i,
    input  save_ready_o, restore_ready_o, restore_err_o, save_done_o, restore_done_o,
           rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, restored_mepc_o, restored_mcause_o,
           hazard_o, level_o, depth_o, csr_rdata_o
  );
endinterface

// File: rtl/shadow_reg_stack.sv
// Multi-level shadow register stack for nested interrupt handling.
// On a save it captures mepc/mcause into a new frame and then copies the GPRs listed in RegMap
// into that frame, one register per cycle via the GPR read port. On a restore it writes the top
// frame back into the GPR file, one register per cycle, and pops the frame.
// Ports:
//   clk_i : clock.
//   rst_i : asynchronous, active-high reset; aborts any operation in flight.
//   bus   : shadow_reg_stack_if.slave carrying the handshakes, GPR ports, hazard query and
//           top-frame CSR readback.
module shadow_reg_stack #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NrShadowRegs = 16,
  parameter int unsigned Depth        = 4,
  // GPR index of frame entry i, entry 0 in the LSBs.
  parameter logic [NrShadowRegs*5-1:0] RegMap = {
    5'd31, 5'd30, 5'd29, 5'd28, 5'd17, 5'd16, 5'd15, 5'd14,
    5'd13, 5'd12, 5'd11, 5'd10, 5'd7,  5'd6,  5'd5,  5'd1
  }
) (
  input logic               clk_i,
  input logic               rst_i,
  shadow_reg_stack_if.slave bus
);

  localparam int unsigned DepthW = $clog2(Depth + 1);
  localparam int unsigned FrameW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned IdxW   = (NrShadowRegs > 1) ? $clog2(NrShadowRegs) : 1;
  localparam int unsigned CsrAW  = $clog2(NrShadowRegs + 2);

  localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NrShadowRegs - 1);
  localparam logic [CsrAW-1:0]  CsrMepc   = CsrAW'(NrShadowRegs);
  localparam logic [CsrAW-1:0]  CsrMcause = CsrAW'(NrShadowRegs + 1);

  function automatic logic [4:0] map_at(input int unsigned i);
    return RegMap[i*5 +: 5];
  endfunction

  function automatic bit map_has_dup();
    for (int unsigned a = 0; a < NrShadowRegs; a++) begin
      for (int unsigned b = a + 1; b < NrShadowRegs; b++) begin
        if (RegMap[a*5 +: 5] == RegMap[b*5 +: 5]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  localparam bit RegMapDup = map_has_dup();

  typedef enum logic [1:0] {StIdle, StSave, StRestore} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [FrameW-1:0] frame_q, frame_d;

  // Frame storage; contents are don't-care after reset, so it carries no reset.
  logic [XLEN-1:0] frame_gpr_q    [Depth][NrShadowRegs];
  logic [XLEN-1:0] frame_mepc_q   [Depth];
  logic [XLEN-1:0] frame_mcause_q [Depth];

  logic              store_csr;
  logic              store_gpr;
  logic [FrameW-1:0] push_frame;
  logic [FrameW-1:0] top_frame;
  logic              stack_empty;

  // A new frame always lands at index depth; the top valid frame is depth-1.
  assign push_frame  = FrameW'(depth_q);
  assign top_frame   = FrameW'(depth_q - DepthW'(1));
  assign stack_empty = (depth_q == '0);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake/port outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    frame_d = frame_q;

    store_csr = 1'b0;
    store_gpr = 1'b0;

    bus.save_ready_o    = 1'b0;
    bus.restore_ready_o = 1'b0;
    bus.restore_err_o   = 1'b0;
    bus.save_done_o     = 1'b0;
    bus.restore_done_o  = 1'b0;
    bus.rf_raddr_o      = 5'd0;
    bus.rf_we_o         = 1'b0;
    bus.rf_waddr_o      = 5'd0;
    bus.rf_wdata_o      = '0;

    case (state_q)
      StIdle: begin
        bus.save_ready_o = (depth_q < DepthFull);
        // A new interrupt preempts a concurrent mret.
        bus.restore_ready_o = !stack_empty && !bus.save_valid_i;
        bus.restore_err_o   = bus.restore_valid_i && stack_empty && !bus.save_valid_i;

        if (bus.save_valid_i && bus.save_ready_o) begin
          store_csr = 1'b1;
          frame_d   = push_frame;
          idx_d     = '0;
          state_d   = StSave;
        end else if (bus.restore_valid_i && bus.restore_ready_o) begin
          frame_d = top_frame;
          idx_d   = '0;
          state_d = StRestore;
        end
      end

      StSave: begin
        bus.rf_raddr_o = map_at(32'(idx_q));
        store_gpr      = 1'b1;
        if (idx_q == LastIdx) begin
          bus.save_done_o = 1'b1;
          depth_d         = depth_q + DepthW'(1);
          idx_d           = '0;
          state_d         = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      StRestore: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = map_at(32'(idx_q));
        bus.rf_wdata_o = frame_gpr_q[frame_q][idx_q];
        if (idx_q == LastIdx) begin
          bus.restore_done_o = 1'b1;
          depth_d            = depth_q - DepthW'(1);
          idx_d              = '0;
          state_d            = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard: a mapped GPR at or beyond the current entry has not been moved yet.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.hazard_o = 1'b0;
    if (state_q != StIdle && bus.hazard_addr_i != 5'd0) begin
      for (int unsigned j = 0; j < NrShadowRegs; j++) begin
        if (j >= 32'(idx_q) && map_at(j) == bus.hazard_addr_i) begin
          bus.hazard_o = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Top-frame views for the CSR regfile.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.restored_mepc_o   = '0;
    bus.restored_mcause_o = '0;
    bus.csr_rdata_o       = '0;
    if (!stack_empty) begin
      bus.restored_mepc_o   = frame_mepc_q[top_frame];
      bus.restored_mcause_o = frame_mcause_q[top_frame];
      if (bus.csr_raddr_i < CsrMepc) begin
        bus.csr_rdata_o = frame_gpr_q[top_frame][bus.csr_raddr_i[IdxW-1:0]];
      end else if (bus.csr_raddr_i == CsrMepc) begin
        bus.csr_rdata_o = frame_mepc_q[top_frame];
      end else if (bus.csr_raddr_i == CsrMcause) begin
        bus.csr_rdata_o = frame_mcause_q[top_frame];
      end
    end
  end

  always_comb begin
    bus.depth_o = depth_q;
    bus.level_o = (state_q == StIdle) ? 5'd0 : 5'(idx_q);
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      depth_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      frame_q <= frame_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_csr) begin
      frame_mepc_q[push_frame]   <= bus.save_mepc_i;
      frame_mcause_q[push_frame] <= bus.save_mcause_i;
    end
    if (store_gpr) begin
      frame_gpr_q[frame_q][idx_q] <= bus.rf_rdata_i;
    end
  end

  // Two entries naming the same GPR would make restore order-dependent.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!RegMapDup);
    end
  end

endmodule
